// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, shared-ALU and status signals of the two-port ALU arbiter
interface alu_arbiter_if;
    logic       req0, req1;
    logic [2:0] op0, op1;
    logic [7:0] a0, b0, a1, b1;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic [2:0] alu_op;
    logic [7:0] alu_a, alu_b;
    logic       gnt0, gnt1;
    logic       done0, done1;
    logic [7:0] result_out;
    logic       zero_out;
    logic       err;
    logic       busy;

    modport slave (
        input  req0, req1, op0, op1, a0, b0, a1, b1, alu_result, alu_zero,
        output alu_op, alu_a, alu_b, gnt0, gnt1, done0, done1, result_out, zero_out, err, busy
    );

    modport master (
        output req0, req1, op0, op1, a0, b0, a1, b1, alu_result, alu_zero,
        input  alu_op, alu_a, alu_b, gnt0, gnt1, done0, done1, result_out, zero_out, err, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one external ALU between two requesters
module alu_arbiter (
    input logic          clk,
    input logic          reset,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t     state;
    logic       last, owner;
    logic [2:0] op_l;
    logic [7:0] a_l, b_l;
    logic       win, valid_w, valid_l;
    logic [2:0] op_w;
    logic [7:0] a_w, b_w;

    // pick the winner (alternate on contention) and classify opcodes
    always_comb begin
        win     = (bus.req0 & bus.req1) ? ~last : bus.req1;
        op_w    = win ? bus.op1 : bus.op0;
        a_w     = win ? bus.a1 : bus.a0;
        b_w     = win ? bus.b1 : bus.b0;
        valid_w = (op_w != 3'b000) && (op_w != 3'b111);
        valid_l = (op_l != 3'b000) && (op_l != 3'b111);
    end

    // IDLE -> ISSUE -> WAIT -> DONE sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            last           <= 1'b1;
            owner          <= 1'b0;
            op_l           <= '0;
            a_l            <= '0;
            b_l            <= '0;
            bus.alu_op     <= '0;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
            bus.gnt0       <= 1'b0;
            bus.gnt1       <= 1'b0;
            bus.done0      <= 1'b0;
            bus.done1      <= 1'b0;
            bus.result_out <= '0;
            bus.zero_out   <= 1'b0;
            bus.err        <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req0 | bus.req1) begin
                    state      <= ISSUE;
                    last       <= win;
                    owner      <= win;
                    op_l       <= op_w;
                    a_l        <= a_w;
                    b_l        <= b_w;
                    bus.gnt0   <= ~win;
                    bus.gnt1   <= win;
                    bus.busy   <= 1'b1;
                    bus.alu_op <= valid_w ? op_w : 3'b000;
                    bus.alu_a  <= a_w;
                    bus.alu_b  <= b_w;
                end
                ISSUE: begin
                    state    <= WAIT;
                    bus.gnt0 <= 1'b0;
                    bus.gnt1 <= 1'b0;
                end
                WAIT: begin
                    state          <= DONE;
                    bus.alu_op     <= '0;
                    bus.alu_a      <= '0;
                    bus.alu_b      <= '0;
                    bus.result_out <= (!valid_l || (op_l == 3'b011 && a_l == b_l)) ? 8'h00 : bus.alu_result;
                    bus.zero_out   <= (op_l == 3'b110) && bus.alu_zero;
                    bus.err        <= !valid_l;
                    bus.done0      <= ~owner;
                    bus.done1      <= owner;
                end
                DONE: begin
                    state     <= IDLE;
                    bus.done0 <= 1'b0;
                    bus.done1 <= 1'b0;
                    bus.busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed table-driven checks of the ALU arbiter against a behavioural ALU
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    alu_arbiter_if intf ();

    alu_arbiter dut (.clk(clk), .reset(reset), .bus(intf.slave));

    always #5 clk = ~clk;

    // behavioural shared ALU; compare of equal operands returns junk the arbiter must mask
    always_comb begin
        intf.alu_zero   = intf.alu_a == intf.alu_b;
        intf.alu_result = intf.alu_op == 3'b001 ? intf.alu_a + intf.alu_b :
                          intf.alu_op == 3'b010 ? ~(intf.alu_a & intf.alu_b) :
                          intf.alu_op == 3'b011 ? (intf.alu_a == intf.alu_b ? 8'hFF : (intf.alu_a < intf.alu_b ? 8'h01 : 8'h00)) :
                          intf.alu_op == 3'b100 ? intf.alu_a << intf.alu_b[2:0] :
                          intf.alu_op == 3'b101 ? intf.alu_a >> intf.alu_b[2:0] :
                          intf.alu_op == 3'b110 ? 8'h00 : 8'hEE;
    end

    typedef struct {
        logic       who;
        logic [2:0] op;
        logic [7:0] a, b;
        logic [2:0] xop;
        logic [7:0] xres;
        logic       xz, xerr;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {intf.gnt0, intf.gnt1, intf.done0, intf.done1, intf.busy, intf.result_out,
                   intf.zero_out, intf.err, intf.alu_op, intf.alu_a, intf.alu_b}, 32'h0);
    endtask

    task automatic do_vec(input vec_t v, input int idx);
        intf.req0 = !v.who;
        intf.req1 = v.who;
        if (v.who) begin
            intf.op1 = v.op; intf.a1 = v.a; intf.b1 = v.b;
            intf.op0 = 3'b001; intf.a0 = 8'h55; intf.b0 = 8'hAA;
        end else begin
            intf.op0 = v.op; intf.a0 = v.a; intf.b0 = v.b;
            intf.op1 = 3'b001; intf.a1 = 8'h55; intf.b1 = 8'hAA;
        end
        @(posedge clk); #1;
        chk($sformatf("v%0d gnt", idx), {intf.gnt1, intf.gnt0}, {v.who, !v.who});
        chk($sformatf("v%0d issue busy", idx), intf.busy, 1);
        chk($sformatf("v%0d issue alu", idx), {intf.alu_op, intf.alu_a, intf.alu_b}, {v.xop, v.a, v.b});
        intf.req0 = 0; intf.req1 = 0;
        intf.op0 = 3'b010; intf.a0 = 8'hFF; intf.b0 = 8'hFF;
        intf.op1 = 3'b010; intf.a1 = 8'hFF; intf.b1 = 8'hFF;
        @(posedge clk); #1;
        chk($sformatf("v%0d wait gnt", idx), {intf.gnt1, intf.gnt0}, 0);
        chk($sformatf("v%0d wait alu", idx), {intf.alu_op, intf.alu_a, intf.alu_b}, {v.xop, v.a, v.b});
        @(posedge clk); #1;
        chk($sformatf("v%0d done", idx), {intf.done1, intf.done0}, {v.who, !v.who});
        chk($sformatf("v%0d result", idx), {intf.result_out, intf.zero_out, intf.err}, {v.xres, v.xz, v.xerr});
        chk($sformatf("v%0d done alu", idx), {intf.alu_op, intf.alu_a, intf.alu_b}, 0);
        @(posedge clk); #1;
        chk($sformatf("v%0d idle", idx), {intf.done1, intf.done0, intf.busy, intf.alu_op}, 0);
        chk($sformatf("v%0d hold", idx), {intf.result_out, intf.zero_out, intf.err}, {v.xres, v.xz, v.xerr});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{0, 3'b001, 8'h05, 8'h03, 3'b001, 8'h08, 0, 0};
        vecs[1]  = '{1, 3'b110, 8'h2A, 8'h2A, 3'b110, 8'h00, 1, 0};
        vecs[2]  = '{1, 3'b001, 8'h01, 8'h01, 3'b001, 8'h02, 0, 0};
        vecs[3]  = '{0, 3'b011, 8'h10, 8'h10, 3'b011, 8'h00, 0, 0};
        vecs[4]  = '{0, 3'b011, 8'h01, 8'h10, 3'b011, 8'h01, 0, 0};
        vecs[5]  = '{0, 3'b111, 8'h03, 8'h03, 3'b000, 8'h00, 0, 1};
        vecs[6]  = '{1, 3'b010, 8'hF0, 8'h3C, 3'b010, 8'hCF, 0, 0};
        vecs[7]  = '{0, 3'b100, 8'h81, 8'h01, 3'b100, 8'h02, 0, 0};
        vecs[8]  = '{1, 3'b101, 8'h80, 8'h03, 3'b101, 8'h10, 0, 0};
        vecs[9]  = '{1, 3'b000, 8'h07, 8'h07, 3'b000, 8'h00, 0, 1};
        vecs[10] = '{0, 3'b110, 8'h12, 8'h34, 3'b110, 8'h00, 0, 0};
        intf.req0 = 0; intf.req1 = 0;
        intf.op0 = 0; intf.a0 = 0; intf.b0 = 0;
        intf.op1 = 0; intf.a1 = 0; intf.b1 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset outputs");
        // contention from reset: grants alternate starting with requester 0
        reset = 0;
        intf.req0 = 1; intf.req1 = 1;
        intf.op0 = 3'b001; intf.a0 = 8'h01; intf.b0 = 8'h02;
        intf.op1 = 3'b001; intf.a1 = 8'h10; intf.b1 = 8'h20;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("rr%0d gnt", i), {intf.gnt1, intf.gnt0}, (i % 2) ? 2'b10 : 2'b01);
            @(posedge clk); @(posedge clk); #1;
            chk($sformatf("rr%0d done", i), {intf.done1, intf.done0}, (i % 2) ? 2'b10 : 2'b01);
            chk($sformatf("rr%0d result", i), intf.result_out, (i % 2) ? 8'h30 : 8'h03);
            @(posedge clk); #1;
            chk($sformatf("rr%0d idle busy", i), intf.busy, 0);
        end
        intf.req0 = 0; intf.req1 = 0;
        for (int i = 0; i < 11; i++) do_vec(vecs[i], i);
        // reset during WAIT aborts without a done pulse
        intf.req0 = 1; intf.op0 = 3'b001; intf.a0 = 8'h11; intf.b0 = 8'h22;
        @(posedge clk); #1;
        chk("abort gnt", intf.gnt0, 1);
        intf.req0 = 0;
        @(posedge clk); #1;
        chk("abort in wait", intf.busy, 1);
        reset = 1;
        @(posedge clk); #1;
        chk_all_zero("abort reset outputs");
        reset = 0;
        @(posedge clk); #1;
        chk("abort no done", {intf.done1, intf.done0, intf.busy}, 0);
        do_vec('{1, 3'b001, 8'h05, 8'h05, 3'b001, 8'h0A, 0, 0}, 11);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001: The block SHALL have exactly one clock, `clk`, and a synchronous active-high reset, `reset`; all state SHALL change only on the rising edge of `clk`.
REQ-002: Ports SHALL be:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0, req1  in  1 each  requester 0/1 wants an ALU operation
- op0, op1  in  3 each  requested ALU opcode
- a0, b0, a1, b1  in  8 each  requested operands
- alu_result  in  8  result from the shared ALU
- alu_zero  in  1  zero/equal flag from the shared ALU
- alu_op  out  3  opcode driven to the shared ALU
- alu_a, alu_b  out  8 each  operands driven to the shared ALU
- gnt0, gnt1  out  1 each  one-cycle pulse: request accepted and operands latched
- done0, done1  out  1 each  one-cycle pulse: result_out/zero_out/err valid for that requester
- result_out  out  8  captured result
- zero_out  out  1  captured equal flag
- err  out  1  opcode was invalid
- busy  out  1  high in any state other than IDLE

Function
REQ-003: The controller SHALL use the opcode map 001 add, 010 nand, 011 compare, 100 shift-left, 101 shift-right, 110 equal; 000 and 111 SHALL be invalid.
REQ-004: The FSM SHALL have four states: IDLE, ISSUE, WAIT, DONE. Transitions:
- IDLE->ISSUE on any req
- ISSUE->WAIT unconditionally
- WAIT->DONE unconditionally
- DONE->IDLE unconditionally
REQ-005: In IDLE, requests SHALL be sampled. With one requester active, that requester SHALL win. With both active, the requester not served last SHALL win. The last-served pointer SHALL reset to 1, so requester 0 wins first.
REQ-006: On the IDLE->ISSUE edge, the winner's op/a/b SHALL be latched internally. The matching gnt SHALL be high for exactly the ISSUE cycle. The requester MAY change operands after gnt.
REQ-007: alu_op/alu_a/alu_b SHALL carry the latched values during ISSUE and WAIT, and SHALL be 000/0x00/0x00 in all other states. This guarantees an alu_op transition on every issue, including back-to-back identical opcodes.
REQ-008: For an invalid opcode, alu_op SHALL stay 000 throughout. result_out SHALL be 0x00, zero_out 0, and err 1 at DONE.
REQ-009: On the WAIT->DONE edge, result_out SHALL capture alu_result, subject to two rules:
- For op 011 with equal operands, result_out SHALL be forced to 0x00 (ALU output is unspecified in that case).
- zero_out SHALL be alu_zero for op 110 and 0 for every other op.
REQ-010: Exactly one done (the owner's) SHALL be high for exactly the DONE cycle. result_out/zero_out/err SHALL hold their values until the next DONE capture.
REQ-011: Latency SHALL be: req high at IDLE edge E0 -> gnt in cycle E0..E1 -> done in cycle E2..E3. Throughput SHALL be one operation per 4 cycles.
REQ-012: Requests SHALL be ignored in ISSUE, WAIT and DONE. A req still high at the next IDLE edge SHALL be served as a new operation. A requester SHALL drop req on the edge it samples done to avoid reissue.
REQ-013: The last-served pointer SHALL update on the IDLE->ISSUE edge.
REQ-014: busy SHALL be 0 only in IDLE.
REQ-015: The arithmetic of every valid op SHALL be performed by the shared ALU, never by the controller; the controller's only result logic SHALL be the compare-equal override and the zero_out mask.

Reset
REQ-016: When reset is sampled high, the FSM SHALL go to IDLE and the pointer to 1, and every output SHALL be 0 on the following cycle. Outputs: gnt0/1, done0/1, busy, result_out, zero_out, err, alu_op, alu_a, alu_b.
REQ-017: Reset in ISSUE, WAIT or DONE SHALL abort the in-flight operation with no done pulse. Reset SHALL take priority over all transitions.
REQ-018: The first IDLE sample after reset SHALL occur on the first edge at which reset is low.

Verification
REQ-019: Single add: req0, op0=001, a0=0x05, b0=0x03 -> gnt0 at cycle 1, alu_op=001 in cycles 1-2, done0 at cycle 3, result_out=0x08, zero_out=0, err=0.
REQ-020: Contention: req0 and req1 held high together from reset -> grants alternate 0,1,0,1. Each op takes 4 cycles. done always matches the preceding gnt.
REQ-021: Equal op: req1, op1=110, a1=b1=0x2A -> zero_out=1. Then op1=001, 0x01+0x01 -> zero_out=0, result_out=0x02.
REQ-022: Compare corner: op=011, a=b=0x10 -> result_out=0x00. Then a=0x01, b=0x10 -> result_out=0x01.
REQ-023: Invalid op: op0=111 -> alu_op stays 000, done0 with err=1, result_out=0x00.
REQ-024: Reset mid-op: assert reset during WAIT -> no done pulse. Next cycle all outputs are 0 and busy=0. A subsequent req1 alone is granted normally.
